// File: rtl/kronecker_stream.sv
// kronecker_stream
// ----------------
// Computes the Kronecker product TP = A (x) B one element at a time, using
// a single registered multiplier, and sends the elements out in row-major
// order.
//
// Matrix packing (A and B use the same layout): element (r,c) of an
// R x C matrix sits at bits [(R*C-1-(r*C+c))*word_size +: word_size].
// Element (0,0) is therefore in the most significant word.
//
// Element definition: TP[x*b_rows+z][y*b_cols+w] = A[x][y] * B[z][w].
// The product is truncated to its low word_size bits and is unsigned.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   start      request a new product; sampled only in IDLE
//   A, B       packed input matrices, captured on start acceptance
//   out_valid  out_data/out_row/out_col/out_last carry an element
//   out_ready  consumer accepts the current element
//   out_data   TP element value (low word_size bits of the product)
//   out_row    TP row index of out_data
//   out_col    TP column index of out_data
//   out_last   current element is TP[TP_ROWS-1][TP_COLS-1]
//   busy       high from the cycle after start acceptance until done
//   done       one-cycle pulse after the last element transfers
//   state_dbg  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// Handshake: an element transfers on a rising edge where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0, the
// out_data/out_row/out_col/out_last outputs hold stable. out_valid never
// drops before its element has transferred.

module kronecker_stream #(
  parameter int word_size = 32,
  parameter int a_rows    = 2,
  parameter int a_cols    = 2,
  parameter int b_rows    = 2,
  parameter int b_cols    = 2,
  localparam int TP_ROWS  = a_rows * b_rows,
  localparam int TP_COLS  = a_cols * b_cols,
  localparam int N        = TP_ROWS * TP_COLS,
  localparam int ROW_W    = (TP_ROWS > 1) ? $clog2(TP_ROWS) : 1,
  localparam int COL_W    = (TP_COLS > 1) ? $clog2(TP_COLS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [a_rows*a_cols*word_size-1:0] A,
  input  logic [b_rows*b_cols*word_size-1:0] B,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [word_size-1:0]               out_data,
  output logic [ROW_W-1:0]                   out_row,
  output logic [COL_W-1:0]                   out_col,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         state_dbg
);

  // ---------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------
  localparam int A_ELEMS = a_rows * a_cols;
  localparam int B_ELEMS = b_rows * b_cols;
  localparam int A_W     = A_ELEMS * word_size;
  localparam int B_W     = B_ELEMS * word_size;

  // Counter widths; a dimension of 1 still gets a 1-bit counter that
  // simply stays at 0.
  localparam int XW = (a_rows > 1) ? $clog2(a_rows) : 1;
  localparam int YW = (a_cols > 1) ? $clog2(a_cols) : 1;
  localparam int ZW = (b_rows > 1) ? $clog2(b_rows) : 1;
  localparam int WW = (b_cols > 1) ? $clog2(b_cols) : 1;

  localparam logic [XW-1:0] X_MAX = XW'(a_rows - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(a_cols - 1);
  localparam logic [ZW-1:0] Z_MAX = ZW'(b_rows - 1);
  localparam logic [WW-1:0] W_MAX = WW'(b_cols - 1);

  // ---------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;

  // Captured operands. Only written on start acceptance, so they need no
  // reset: nothing reads them before the first capture.
  logic [A_W-1:0] a_reg;
  logic [B_W-1:0] b_reg;

  // Indices of the element currently presented on the output.
  // Row = x*b_rows + z, column = y*b_cols + w.
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ZW-1:0] z;
  logic [WW-1:0] w;

  // Indices of the element that follows the presented one.
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [ZW-1:0] nz;
  logic [WW-1:0] nw;
  logic          nlast;

  // Multiplier operand selection.
  logic [XW-1:0]        mx;
  logic [YW-1:0]        my;
  logic [ZW-1:0]        mz;
  logic [WW-1:0]        mw;
  logic [A_W-1:0]       src_a;
  logic [B_W-1:0]       src_b;
  int                   a_idx;
  int                   b_idx;
  logic [word_size-1:0] op_a;
  logic [word_size-1:0] op_b;
  logic [word_size-1:0] prod;

  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // Next-index generation: w is the fastest counter, then y, then z, then
  // x. Walking in this order visits TP in row-major order without any
  // division, because TP column = y*b_cols + w and TP row = x*b_rows + z.
  // ---------------------------------------------------------------------
  always_comb begin
    nx = x;
    ny = y;
    nz = z;
    nw = w;
    if (w == W_MAX) begin
      nw = '0;
      if (y == Y_MAX) begin
        ny = '0;
        if (z == Z_MAX) begin
          nz = '0;
          if (x == X_MAX) begin
            nx = '0;
          end else begin
            nx = x + 1'b1;
          end
        end else begin
          nz = z + 1'b1;
        end
      end else begin
        ny = y + 1'b1;
      end
    end else begin
      nw = w + 1'b1;
    end
  end

  // The following element is the final one when every next index is at
  // its maximum.
  assign nlast = (nx == X_MAX) && (ny == Y_MAX) && (nz == Z_MAX) && (nw == W_MAX);

  // ---------------------------------------------------------------------
  // Operand selection for the single multiplier.
  // In IDLE, the first element (0,0) is formed straight from the input
  // ports so it can be registered on the same edge that captures A and B.
  // Otherwise, the multiplier works on the captured copies at the next
  // indices.
  // ---------------------------------------------------------------------
  always_comb begin
    src_a = a_reg;
    src_b = b_reg;
    mx    = nx;
    my    = ny;
    mz    = nz;
    mw    = nw;
    if (state == S_IDLE) begin
      src_a = A;
      src_b = B;
      mx    = '0;
      my    = '0;
      mz    = '0;
      mw    = '0;
    end
    a_idx = A_ELEMS - 1 - (int'(mx) * a_cols + int'(my));
    b_idx = B_ELEMS - 1 - (int'(mz) * b_cols + int'(mw));
    op_a  = src_a[a_idx*word_size +: word_size];
    op_b  = src_b[b_idx*word_size +: word_size];
    // Result width equals operand width, so only the low word_size bits
    // of the full product are kept.
    prod  = op_a * op_b;
  end

  // ---------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      w         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            w         <= '0;
            out_data  <= prod;
            out_row   <= '0;
            out_col   <= '0;
            // With a single-element product, (0,0) is also the last one.
            out_last  <= (N == 1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end

        S_RUN: begin
          // out_valid is 1 for the whole of RUN, so out_ready alone
          // marks a transfer here.
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              x        <= nx;
              y        <= ny;
              z        <= nz;
              w        <= nw;
              out_data <= prod;
              out_row  <= ROW_W'(int'(nx) * b_rows + int'(nz));
              out_col  <= COL_W'(int'(ny) * b_cols + int'(nw));
              out_last <= nlast;
            end
          end
        end

        S_DONE: begin
          // The done pulse lasts exactly one cycle. A start seen during
          // this cycle is deliberately ignored.
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/kronecker_stream.md
Name: kronecker_stream

Overview:
- Sequential, single-multiplier Kronecker product engine.
- On `start`, captures packed matrices A and B. Streams the product TP = A ⊗ B one element per cycle, in row-major order, over a valid/ready interface.
- Reads the same MSB-first, row-major packed vector format as the combinational Kronecker block.
- Used where downstream logic consumes elements serially and a fully parallel multiplier array is too costly.

Parameters:
- word_size, 32, width of each matrix element and of each output product.
- a_rows, 2, rows in A.
- a_cols, 2, columns in A.
- b_rows, 2, rows in B.
- b_cols, 2, columns in B.
- Derived localparams:
  - TP_ROWS = a_rows*b_rows
  - TP_COLS = a_cols*b_cols
  - N = TP_ROWS*TP_COLS
  - ROW_W = max(1, clog2(TP_ROWS))
  - COL_W = max(1, clog2(TP_COLS))

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  request a new product; sampled only in IDLE.
- A  in  a_rows*a_cols*word_size  packed matrix A.
- B  in  b_rows*b_cols*word_size  packed matrix B.
- out_valid  out  1  out_data/out_row/out_col/out_last are valid.
- out_ready  in  1  consumer accepts the current element.
- out_data  out  word_size  TP element value.
- out_row  out  ROW_W  TP row index of out_data.
- out_col  out  COL_W  TP column index of out_data.
- out_last  out  1  current element is TP[TP_ROWS-1][TP_COLS-1].
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse after the last element transfers.

Behaviour:
- Packing: element (r,c) of A occupies bits [(a_rows*a_cols-1-(r*a_cols+c))*word_size +: word_size]. Element (0,0) is at the MSBs. B uses the same layout with b_rows/b_cols.
- Element definition: TP[x*b_rows+z][y*b_cols+w] = A[x][y]*B[z][w].
  - The product is truncated to its low word_size bits and treated as unsigned.
  - No saturation, no overflow flag.
- Index generation: nested counters x, z, y, w (w fastest, then y, z, x). No dividers. out_row = x*b_rows+z; out_col = y*b_cols+w.
- Reset (rst_n low at a clock edge):
  - state returns to IDLE.
  - out_valid, out_last, busy, done, out_data, out_row and out_col all go to 0.
  - Reset aborts any stream in progress; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge, A and B are registered internally, all counters clear, and the state moves to RUN.
  - out_valid=1, busy=1 and element (0,0) appear on the next cycle (latency 1 from start).
- RUN:
  - out_valid held at 1.
  - A transfer occurs on an edge with out_valid & out_ready. The next element is registered and presented the following cycle, so throughput is 1 element/cycle while out_ready stays high.
  - If out_ready=0, out_data/out_row/out_col/out_last hold stable.
  - When the transfer has out_last=1: out_valid goes 0 and the state moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then the state moves to IDLE.
  - start is ignored during this cycle.
- start in RUN or DONE is ignored; captured A/B are unaffected. Changes on A/B inputs after capture have no effect on the stream in progress.
- With out_ready held high and start accepted at edge t:
  - elements transfer at edges t+1 … t+N;
  - done is high during cycle t+N+1;
  - a new start is accepted at edge t+N+2 at the earliest.
- Degenerate case N=1 (all parameters 1): out_last=1 on the first and only element.
- Exactly one registered multiplier (word_size x word_size → low word_size bits) is used.

Test Plan:
1. Default 2x2, 8x32-bit. A=packed{1,2,3,4}, B=packed{5,6,7,8}, start pulse, out_ready=1 → 16 elements in consecutive cycles: 5,6,10,12,7,8,14,16,15,18,20,24,21,24,28,32. out_row/out_col count 0..3 row-major. out_last only on 32. done pulse one cycle after it.
2. Backpressure: same stimulus, out_ready toggled in a pseudo-random pattern → identical 16-value sequence, no drops or duplicates, outputs stable while stalled, done only after the 16th transfer.
3. Truncation, word_size=8: A[0][0]=200, B[0][0]=3 → first out_data=88 (600 mod 256). A[0][0]=255, B[0][0]=255 → 1.
4. Non-square, a_rows=1, a_cols=3, b_rows=2, b_cols=1. A={2,3,4}, B={10,100} → TP is 2x3: 20,30,40,200,300,400. out_last on 400 at (1,2).
5. start pulses and changes on A/B while busy → stream unaffected, no restart. A start during the done cycle is ignored; a start the next cycle begins a new stream.
6. rst_n low for one cycle after the 5th transfer of scenario 1 → next cycle all outputs 0, state IDLE, no done pulse. A fresh start then produces the full 16-element sequence from 5.
